// File: rtl/csi_lane_aligner.sv
// Two-lane CSI-2 aligner: per-lane bit-offset hunt for the HS sync byte, inter-lane
// deskew through small per-lane delay buffers, and merge into 16-bit words with SOP.
module csi_lane_aligner #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         SKEW_MAX  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs_active,
  input  logic        raw_valid,
  input  logic [7:0]  raw_lane0,
  input  logic [7:0]  raw_lane1,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        locked,
  output logic        sync_err
);

  localparam int PTR_W = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;
  localparam int CNT_W = $clog2(SKEW_MAX + 2);

  typedef enum logic [1:0] {HUNT, SKEW_WAIT, LOCKED, WAIT_LP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cur_q   [2];
  logic [2:0]       off_q   [2];
  logic             early_q;
  logic             skewed_q;
  logic             first_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]       buf_q   [2][SKEW_MAX];

  logic [7:0]  raw      [2];
  logic [15:0] win      [2];
  logic [1:0]  hit;
  logic [2:0]  hit_off  [2];
  logic [7:0]  aligned  [2];
  logic [7:0]  lane_out [2];
  logic        late;
  logic        sync_err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == SKEW_MAX - 1) ? '0 : p + 1'b1;
  endfunction

  assign late   = ~early_q;
  assign locked = (state_q == LOCKED);

  // The window seen on a beat is {incoming byte, last byte}; bit 0 is oldest.
  always_comb begin
    raw[0] = raw_lane0;
    raw[1] = raw_lane1;
    for (int i = 0; i < 2; i++) begin
      win[i]     = {raw[i], cur_q[i]};
      hit[i]     = 1'b0;
      hit_off[i] = '0;
      // Descending scan so the lowest matching offset is the one that sticks.
      for (int k = 7; k >= 0; k--) begin
        if (win[i][k +: 8] == SYNC_BYTE) begin
          hit[i]     = 1'b1;
          hit_off[i] = 3'(k);
        end
      end
      aligned[i]  = win[i][off_q[i] +: 8];
      lane_out[i] = (skewed_q && (early_q == 1'(i))) ? buf_q[i][rd_ptr_q] : aligned[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    sync_err_d = 1'b0;
    if (raw_valid) begin
      case (state_q)
        HUNT: begin
          if (&hit)      state_d = LOCKED;
          else if (|hit) state_d = SKEW_WAIT;
        end
        SKEW_WAIT: begin
          if (int'(cnt_q) + 1 > SKEW_MAX) begin
            state_d    = WAIT_LP;
            sync_err_d = 1'b1;
          end else if (hit[late]) begin
            state_d = LOCKED;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !hs_active) begin
      // NOTE: the deskew buffers are cleared too; they are tiny and a stale byte must never leak out.
      state_q   <= HUNT;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      sync_err  <= 1'b0;
      early_q   <= 1'b0;
      skewed_q  <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        cur_q[i] <= '0;
        off_q[i] <= '0;
        for (int j = 0; j < SKEW_MAX; j++) buf_q[i][j] <= '0;
      end
      if (reset) out_data <= '0;
    end else begin
      state_q   <= state_d;
      sync_err  <= sync_err_d;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      if (raw_valid) begin
        cur_q[0] <= raw[0];
        cur_q[1] <= raw[1];
        case (state_q)
          HUNT: begin
            if (|hit) begin
              for (int i = 0; i < 2; i++) if (hit[i]) off_q[i] <= hit_off[i];
              early_q  <= ~hit[0];
              skewed_q <= ~(&hit);
              first_q  <= 1'b1;
              cnt_q    <= '0;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
            end
          end
          SKEW_WAIT: begin
            buf_q[early_q][wr_ptr_q] <= aligned[early_q];
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            cnt_q    <= cnt_q + 1'b1;
            if (hit[late]) off_q[late] <= hit_off[late];
          end
          LOCKED: begin
            out_valid <= 1'b1;
            out_sop   <= first_q;
            first_q   <= 1'b0;
            out_data  <= {lane_out[1], lane_out[0]};
            if (skewed_q) begin
              buf_q[early_q][wr_ptr_q] <= aligned[early_q];
              wr_ptr_q <= ptr_inc(wr_ptr_q);
              rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csi_lane_aligner.sv
// Self-checking bench for csi_lane_aligner: a fixed vector table, directed corner
// sequences, and randomized bursts checked against a bit-stream-level reference model.
module tb_csi_lane_aligner;

  localparam int SKEW_MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hs_active;
  logic        raw_valid;
  logic [7:0]  raw_lane0;
  logic [7:0]  raw_lane1;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        locked;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay0 [64];
  logic [7:0] pay1 [64];

  typedef struct {
    logic        hs;
    logic        v;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_sop;
    logic        e_locked;
    logic        e_err;
  } vec_t;

  vec_t vecs [8];

  csi_lane_aligner #(.SYNC_BYTE(8'hB8), .SKEW_MAX(SKEW_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .hs_active (hs_active),
    .raw_valid (raw_valid),
    .raw_lane0 (raw_lane0),
    .raw_lane1 (raw_lane1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic step(input logic hs, input logic v, input logic [7:0] b0, input logic [7:0] b1);
    hs_active = hs;
    raw_valid = v;
    raw_lane0 = b0;
    raw_lane1 = b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      pay0[i] = 8'($urandom);
      pay1[i] = 8'($urandom);
    end
  endtask

  // Reference model: lane L carries zeros, then the sync byte starting at stream bit pL,
  // then its payload. The sync is seen on beat pL/8+1 at offset pL%8; payload byte i
  // of a lane surfaces i beats after its sync, and words pair equal payload indices.
  task automatic run_burst(input string tag, input int p0, input int p1, input int npay,
                           input bit gaps);
    logic [511:0] st0, st1;
    int s0, s1, smax, se, d, nbeats, err_beat, idx;
    logic locked_exp;
    st0 = '0;
    st1 = '0;
    st0[p0 +: 8] = 8'hB8;
    st1[p1 +: 8] = 8'hB8;
    for (int i = 0; i < npay; i++) begin
      st0[p0 + 8 + 8*i +: 8] = pay0[i];
      st1[p1 + 8 + 8*i +: 8] = pay1[i];
    end
    s0         = p0 / 8 + 1;
    s1         = p1 / 8 + 1;
    smax       = (s0 > s1) ? s0 : s1;
    se         = (s0 > s1) ? s1 : s0;
    d          = smax - se;
    err_beat   = (d > SKEW_MAX) ? se + SKEW_MAX + 1 : -1;
    nbeats     = smax + npay + 1;
    locked_exp = 1'b0;
    for (int n = 0; n < nbeats; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
          check($sformatf("%s gap_valid b%0d", tag, n), 32'(out_valid), 0);
          check($sformatf("%s gap_locked b%0d", tag, n), 32'(locked), 32'(locked_exp));
          check($sformatf("%s gap_err b%0d", tag, n), 32'(sync_err), 0);
        end
      end
      step(1'b1, 1'b1, st0[8*n +: 8], st1[8*n +: 8]);
      locked_exp = (d <= SKEW_MAX) && (n >= smax);
      check($sformatf("%s locked b%0d", tag, n), 32'(locked), 32'(locked_exp));
      check($sformatf("%s err b%0d", tag, n), 32'(sync_err), 32'(n == err_beat));
      check($sformatf("%s valid b%0d", tag, n), 32'(out_valid),
            32'((d <= SKEW_MAX) && (n > smax)));
      if ((d <= SKEW_MAX) && (n > smax)) begin
        idx = n - smax - 1;
        check($sformatf("%s data b%0d", tag, n), 32'(out_data), 32'({pay1[idx], pay0[idx]}));
        check($sformatf("%s sop b%0d", tag, n), 32'(out_sop), 32'(n == smax + 1));
      end
    end
  endtask

  task automatic drop_hs(input string tag);
    step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    check({tag, " drop_valid"}, 32'(out_valid), 0);
    check({tag, " drop_locked"}, 32'(locked), 0);
    check({tag, " drop_err"}, 32'(sync_err), 0);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    check({tag, " idle_valid"}, 32'(out_valid), 0);
    check({tag, " idle_locked"}, 32'(locked), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hB8, 8'hB8, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 16'h2211, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 16'h4433, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h77, 8'h88, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    hs_active = 1'b0;
    raw_valid = 1'b0;
    raw_lane0 = 8'h00;
    raw_lane1 = 8'h00;
    @(negedge clk);
    step(1'b1, 1'b1, 8'hB8, 8'hB8);
    check("reset data", 32'(out_data), 0);
    check("reset valid", 32'(out_valid), 0);
    check("reset sop", 32'(out_sop), 0);
    check("reset locked", 32'(locked), 0);
    check("reset err", 32'(sync_err), 0);
    reset = 1'b0;

    // Zero offset, zero skew
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].hs, vecs[i].v, vecs[i].b0, vecs[i].b1);
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].e_data));
        check($sformatf("vec%0d sop", i), 32'(out_sop), 32'(vecs[i].e_sop));
      end
      check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].e_locked));
      check($sformatf("vec%0d err", i), 32'(sync_err), 32'(vecs[i].e_err));
    end

    // Lane 0 shifted by three bits, lane 1 aligned
    pay0[0] = 8'h11; pay0[1] = 8'h33; pay0[2] = 8'h55;
    pay1[0] = 8'h22; pay1[1] = 8'h44; pay1[2] = 8'h66;
    run_burst("off3", 3, 0, 3, 1'b0);
    check("off3 lane0_offset", 32'(dut.off_q[0]), 3);
    check("off3 lane1_offset", 32'(dut.off_q[1]), 0);
    drop_hs("off3");

    // Lane 1 two beats late, with gaps between beats
    fill_random(6);
    run_burst("skew2", 0, 16, 6, 1'b1);
    drop_hs("skew2");

    // Skew of three beats: error, WAIT_LP, then a clean re-lock
    fill_random(5);
    run_burst("skew3", 0, 24, 5, 1'b1);
    drop_hs("skew3");
    fill_random(3);
    run_burst("skew3_relock", 8, 9, 3, 1'b0);
    drop_hs("skew3_relock");

    // hs_active drops after five words; next burst syncs at offset 6
    fill_random(5);
    run_burst("mid_drop", 4, 4, 5, 1'b0);
    drop_hs("mid_drop");
    fill_random(4);
    run_burst("relock_k6", 14, 14, 4, 1'b1);
    check("relock_k6 lane0_offset", 32'(dut.off_q[0]), 6);

    // Synchronous reset while locked and a beat is present
    reset = 1'b1;
    step(1'b1, 1'b1, 8'hAA, 8'hBB);
    check("midreset data", 32'(out_data), 0);
    check("midreset valid", 32'(out_valid), 0);
    check("midreset sop", 32'(out_sop), 0);
    check("midreset locked", 32'(locked), 0);
    check("midreset err", 32'(sync_err), 0);
    reset = 1'b0;
    fill_random(4);
    run_burst("post_reset", 5, 13, 4, 1'b1);
    drop_hs("post_reset");

    // Randomized bursts, including skews beyond the limit
    for (int t = 0; t < 24; t++) begin
      int p0, p1, npay;
      p0   = $urandom_range(0, 31);
      p1   = $urandom_range(0, 31);
      npay = $urandom_range(1, 8);
      fill_random(npay);
      run_burst($sformatf("rnd%0d", t), p0, p1, npay, 1'($urandom_range(0, 1)));
      drop_hs($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
